pedal_echo: RTL and testbench
=============================

Name: pedal_echo

Overview:
- Downstream consumer of the pedal ADC serial interface.
- Pulls each converted 8-bit sample through the data_rdy/start_tx handshake and stores it in a circular delay line.
- Produces an echo-processed sample (dry + scaled delayed term, with feedback) on a valid/ack handshake toward the DAC/output stage.

Parameters:
- DEPTH_LOG2, 10, log2 of delay-line depth in samples (1024 samples = 256 ms at 4 kHz)
- DATA_W, 8, sample width; offset binary at ports, two's complement internally

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data_rdy  in  1  ADC sample available (level, held high until next conversion)
- data_adc  in  DATA_W  ADC sample, offset binary (0x80 = midscale)
- start_tx  out  1  one-cycle request to ADC to transfer sample
- enable  in  1  1 = echo active, 0 = bypass
- delay_len  in  DEPTH_LOG2  echo delay in samples; 0 = no echo
- feedback  in  4  feedback gain, value/16
- mix  in  4  wet gain, value/16
- sample_out  out  DATA_W  processed sample, offset binary
- sample_valid  out  1  sample_out valid; held until sample_ack
- sample_ack  in  1  consumer accepts sample_out when sampled high with sample_valid
- overrun  out  1  sticky: a sample edge arrived while busy

Behaviour:
- Reset values: start_tx=0, sample_out=0x80, sample_valid=0, overrun=0; write pointer=0; state=IDLE.
- Reset is asynchronous; asserting it mid-operation aborts the current sample with no RAM write.
- Edge detect: data_rdy registered each cycle; a "new" event is data_rdy=1 while the previous value was 0. The level alone never triggers.
- IDLE -> REQ on new event. REQ: start_tx=1 for exactly one cycle.
- REQ -> WAIT: the ADC updates data_adc at the end of the start_tx cycle.
- WAIT -> LATCH: capture data_adc, convert to signed d = data_adc ^ 0x80.
- LATCH -> READ: RAM read address = (wr_ptr - delay_len) mod 2^DEPTH_LOG2.
- READ -> CALC: z = RAM output; forced to 0 if delay_len==0 or enable==0.
  - y = sat8(d + ((z*mix)>>>4))
  - w = sat8(d + ((z*feedback)>>>4))
  - Arithmetic shift; rounds toward -inf.
  - sat8 clamps to [-128, 127]; intermediates are at least 13-bit signed.
- CALC -> WRITE: RAM[wr_ptr] <= w (w = d when enable==0); wr_ptr <= wr_ptr+1, wrapping 2^DEPTH_LOG2-1 -> 0.
- WRITE -> OUT: sample_out = y ^ 0x80, sample_valid=1.
- OUT -> IDLE on the cycle sample_ack=1; sample_valid drops the next cycle.
- Latency: start_tx is high the cycle after the edge is detected; sample_valid rises 5 cycles after the start_tx cycle.
- Boundary conditions:
  - A new event in any state other than IDLE (including OUT waiting on ack) is dropped: no start_tx, overrun set, sticky until reset.
  - A new event in the same cycle that ack returns the FSM to IDLE is also dropped and sets overrun.
  - sample_ack without sample_valid is ignored.
  - delay_len changes take effect on the next READ; no glitch protection.

Optional Feature:
- Macro: PEDAL_ECHO_CLEAR_EN.
- Defined: after reset deassertion, state INIT sweeps all RAM addresses writing 0, one per cycle (2^DEPTH_LOG2 cycles). New events during INIT are dropped and set overrun. Then IDLE.
- Undefined: no sweep, RAM contents undefined. A saturating fill counter (counts writes, caps at 2^DEPTH_LOG2) forces z=0 while fill count < delay_len.

Decomposition:
- Package pedal_pkg holds:
  - FSM state encoding (IDLE, REQ, WAIT, LATCH, READ, CALC, WRITE, OUT, INIT)
  - MIDSCALE=8'h80, SAT_MAX=127, SAT_MIN=-128
  - offset-binary/signed conversion and sat8 functions
- One sub-module: echo_ram. Single-port synchronous RAM, 2^DEPTH_LOG2 x DATA_W, registered read, one access per cycle.

Test Plan:
- Bypass: enable=0; ADC samples 0x10, 0xF0 -> sample_out 0x10, 0xF0; one start_tx pulse per data_rdy rising edge; sample_valid 5 cycles after start_tx.
- Single echo: enable=1, delay_len=4, mix=8, feedback=0; impulse 0xFF then 0x80 repeated -> outputs 0xFF, 0x80 x3, 0xBF (63), then 0x80.
- Feedback: as above with feedback=8 -> 0xBF at sample 4, 0x9F (31) at sample 8, 0x8F (15) at sample 12.
- Saturation: delay_len=1, mix=15, feedback=15, constant 0xFF input -> sample_out stays 0xFF; constant 0x00 input -> stays 0x00.
- Wrap/overrun: delay_len=2^DEPTH_LOG2-1, run 2^DEPTH_LOG2+5 samples -> wr_ptr wraps and the echo aligns. Hold sample_ack=0 and raise data_rdy again -> no start_tx, overrun=1, first sample still presented.
- Reset mid-op: assert reset during CALC -> all outputs at reset values immediately; the next sample is processed normally. With PEDAL_ECHO_CLEAR_EN, the first delay_len echoes read 0.

Source files
------------

// File: rtl/pedal_pkg.sv
// Shared definitions for the pedal echo block: FSM state encoding,
// sample-format constants and the offset-binary / saturation helpers.
package pedal_pkg;

   typedef enum logic [3:0] {
      IDLE,
      REQ,
      WAIT,
      LATCH,
      READ,
      CALC,
      WRITE,
      OUT,
      INIT
   } state_t;

   localparam logic [7:0] MIDSCALE = 8'h80;
   localparam int         SAT_MAX  = 127;
   localparam int         SAT_MIN  = -128;

   // Offset binary (0x80 = zero) to two's complement
   function automatic logic signed [7:0] to_signed8(input logic [7:0] v);
      return $signed(v ^ MIDSCALE);
   endfunction

   // Two's complement back to offset binary for the output stage
   function automatic logic [7:0] to_offset8(input logic signed [7:0] v);
      return $unsigned(v) ^ MIDSCALE;
   endfunction

   // Clamp a wide signed intermediate into the 8-bit sample range
   function automatic logic signed [7:0] sat8(input logic signed [12:0] v);
      if (v > 13'(SAT_MAX)) begin
         return 8'(SAT_MAX);
      end else if (v < 13'(SAT_MIN)) begin
         return 8'(SAT_MIN);
      end else begin
         return v[7:0];
      end
   endfunction

endpackage

// File: rtl/pedal_echo_if.sv
// Sample path between ADC, echo block and DAC stage: the data_rdy/start_tx
// pull from the ADC and the valid/ack push toward the output.
// master = echo block, slave = surrounding ADC/DAC logic.
interface pedal_echo_if #(
   parameter int DATA_W = 8
);
   logic              data_rdy;
   logic [DATA_W-1:0] data_adc;
   logic              start_tx;
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;
   logic              sample_ack;

   modport master (
      input  data_rdy,
      input  data_adc,
      input  sample_ack,
      output start_tx,
      output sample_out,
      output sample_valid
   );

   modport slave (
      output data_rdy,
      output data_adc,
      output sample_ack,
      input  start_tx,
      input  sample_out,
      input  sample_valid
   );
endinterface

// File: rtl/echo_ram.sv
// Delay-line storage: single-port synchronous RAM with a registered read.
// One access per cycle; a write does not update the read register.
module echo_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Either write the addressed word or register its contents for the next cycle
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/pedal_echo.sv
// Echo processor for the guitar pedal. Pulls ADC samples, keeps a circular
// delay line and emits dry + scaled delayed sample (with feedback) to the DAC.
// Build option PEDAL_ECHO_CLEAR_EN: zero the whole delay line after reset
// (INIT sweep); without it a fill counter masks not-yet-written history.
module pedal_echo
   import pedal_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int DATA_W     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   pedal_echo_if.master          bus,
   input  logic                  enable,
   input  logic [DEPTH_LOG2-1:0] delay_len,
   input  logic [3:0]            feedback,
   input  logic [3:0]            mix,
   output logic                  overrun
);

`ifdef PEDAL_ECHO_CLEAR_EN
   localparam state_t RESET_STATE = INIT;
`else
   localparam state_t RESET_STATE = IDLE;
   localparam logic [DEPTH_LOG2:0] FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
`endif

   state_t state, state_nxt;

   logic                  data_rdy_q;
   logic                  new_evt;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] ram_addr;
   logic                  ram_en;
   logic                  ram_we;
   logic [DATA_W-1:0]     ram_wdata;
   logic [DATA_W-1:0]     ram_rdata;
   logic                  echo_masked;

   logic signed [7:0]  d_reg, y_reg, w_reg;
   logic signed [7:0]  z;
   logic signed [12:0] z_ext, mix_term, fb_term, y_sum, w_sum;

   assign new_evt     = bus.data_rdy & ~data_rdy_q;
   assign bus.start_tx = (state == REQ);

   // Remember last data_rdy level so only a rising edge starts a transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_rdy_q <= 1'b0;
      end else begin
         data_rdy_q <= bus.data_rdy;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RESET_STATE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sequence one sample through request, capture, lookup, compute, store and present
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (new_evt) state_nxt = REQ;
         REQ:   state_nxt = WAIT;
         WAIT:  state_nxt = LATCH;
         LATCH: state_nxt = READ;
         READ:  state_nxt = CALC;
         CALC:  state_nxt = WRITE;
         WRITE: state_nxt = bus.sample_ack ? IDLE : OUT;
         OUT:   if (bus.sample_ack) state_nxt = IDLE;
`ifdef PEDAL_ECHO_CLEAR_EN
         INIT:  if (wr_ptr == '1) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Single RAM port: read the delayed tap in LATCH, write the feedback sample in CALC
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = wr_ptr;
      ram_wdata = $unsigned(w_reg);
      case (state)
         LATCH: begin
            ram_en   = 1'b1;
            ram_addr = wr_ptr - delay_len;
         end
         CALC: begin
            ram_en = 1'b1;
            ram_we = 1'b1;
         end
`ifdef PEDAL_ECHO_CLEAR_EN
         INIT: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_wdata = '0;
         end
`endif
         default: ;
      endcase
   end

   echo_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

`ifdef PEDAL_ECHO_CLEAR_EN
   assign echo_masked = 1'b0;
`else
   logic [DEPTH_LOG2:0] fill;

   // Count samples written since reset so stale RAM is never heard as an echo
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill <= '0;
      end else if (state == CALC && fill != FILL_FULL) begin
         fill <= fill + 1'b1;
      end
   end

   assign echo_masked = (fill < {1'b0, delay_len});
`endif

   // Echo arithmetic: gains are value/16 with an arithmetic shift (rounds toward -inf)
   always_comb begin
      z = $signed(ram_rdata);
      if (delay_len == '0 || !enable || echo_masked) begin
         z = '0;
      end
      z_ext    = 13'(z);
      mix_term = (z_ext * $signed(13'({1'b0, mix}))) >>> 4;
      fb_term  = (z_ext * $signed(13'({1'b0, feedback}))) >>> 4;
      y_sum    = 13'(d_reg) + mix_term;
      w_sum    = 13'(d_reg) + fb_term;
   end

   // Capture the dry sample and the computed wet/feedback results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_reg <= '0;
         y_reg <= '0;
         w_reg <= '0;
      end else begin
         if (state == WAIT) begin
            d_reg <= to_signed8(bus.data_adc);
         end
         if (state == READ) begin
            y_reg <= sat8(y_sum);
            w_reg <= sat8(w_sum);
         end
      end
   end

   // Advance the write pointer after each stored sample (and through the clear sweep)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
      end else if (state == CALC) begin
         wr_ptr <= wr_ptr + 1'b1;
`ifdef PEDAL_ECHO_CLEAR_EN
      end else if (state == INIT) begin
         wr_ptr <= wr_ptr + 1'b1;
`endif
      end
   end

   // Present the result to the DAC and hold it until acknowledged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.sample_out   <= MIDSCALE;
         bus.sample_valid <= 1'b0;
      end else if (state == CALC) begin
         bus.sample_out   <= to_offset8(y_reg);
         bus.sample_valid <= 1'b1;
      end else if ((state == WRITE || state == OUT) && bus.sample_ack) begin
         bus.sample_valid <= 1'b0;
      end
   end

   // Flag any ADC edge that arrives while a sample is still in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (new_evt && state != IDLE) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pedal_echo.sv
// Testbench for pedal_echo: directed scenarios plus randomized samples,
// checked against a behavioural echo model held in this file.
module tb_pedal_echo;

   localparam int DEPTH_LOG2 = 10;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable;
   logic [9:0] delay_len;
   logic [3:0] feedback;
   logic [3:0] mix;
   logic       overrun;

   int compared   = 0;
   int mismatched = 0;

   int hist [DEPTH];
   int n_written;

   pedal_echo_if #(.DATA_W(8)) bus ();

   pedal_echo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .enable    (enable),
      .delay_len (delay_len),
      .feedback  (feedback),
      .mix       (mix),
      .overrun   (overrun)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int floorDiv16(input int v);
      int q;
      q = v / 16;
      if ((v % 16) != 0 && v < 0) q = q - 1;
      return q;
   endfunction

   function automatic int clamp8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) hist[i] = 0;
      n_written = 0;
   endtask

   // Echo reference: history of stored samples indexed by absolute sample number
   task automatic modelStep(input logic [7:0] adc, output logic [7:0] exp_out);
      int d, z, y, w, dl;
      dl = int'(delay_len);
      d  = int'(adc) - 128;
      z  = 0;
      if (enable && dl != 0 && n_written >= dl) begin
         z = hist[((n_written - dl) % DEPTH + DEPTH) % DEPTH];
      end
      y = clamp8(d + floorDiv16(z * int'(mix)));
      w = clamp8(d + floorDiv16(z * int'(feedback)));
      hist[n_written % DEPTH] = w;
      n_written++;
      exp_out = 8'(y + 128);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      modelReset();
`ifdef PEDAL_ECHO_CLEAR_EN
      repeat (DEPTH + 4) @(negedge clk);
`endif
   endtask

   // One full ADC transfer; ack_wait < 0 leaves the result unacknowledged
   task automatic applyStimulus(input logic [7:0] adc, input int ack_wait, output logic [7:0] got);
      int cyc;
      logic [7:0] exp_out;
      modelStep(adc, exp_out);
      @(negedge clk);
      bus.data_rdy = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (bus.start_tx !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("start_tx_latency", cyc, 0);
      bus.data_rdy = 1'b0;
      @(negedge clk);
      bus.data_adc = adc;
      checkOutput("start_tx_single", bus.start_tx, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("valid_early", bus.sample_valid, 1'b0);
      @(negedge clk);
      checkOutput("valid_latency", bus.sample_valid, 1'b1);
      checkOutput("sample_out", bus.sample_out, exp_out);
      got = bus.sample_out;
      if (ack_wait >= 0) begin
         repeat (ack_wait) @(negedge clk);
         checkOutput("valid_hold", bus.sample_valid, 1'b1);
         bus.sample_ack = 1'b1;
         @(negedge clk);
         bus.sample_ack = 1'b0;
         checkOutput("valid_drop", bus.sample_valid, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] got;
      logic [7:0] outs [16];
      int cyc;

      bus.data_rdy   = 1'b0;
      bus.data_adc   = 8'h80;
      bus.sample_ack = 1'b0;
      enable    = 1'b0;
      delay_len = '0;
      feedback  = '0;
      mix       = '0;
      modelReset();

      #12;
      checkOutput("rst_start_tx", bus.start_tx, 1'b0);
      checkOutput("rst_valid", bus.sample_valid, 1'b0);
      checkOutput("rst_sample_out", bus.sample_out, 8'h80);
      checkOutput("rst_overrun", overrun, 1'b0);
      doReset();

      // Bypass
      enable = 1'b0;
      applyStimulus(8'h10, 0, got);
      checkOutput("bypass_10", got, 8'h10);
      applyStimulus(8'hF0, 1, got);
      checkOutput("bypass_F0", got, 8'hF0);

      // Ack while nothing is valid is ignored
      @(negedge clk);
      bus.sample_ack = 1'b1;
      @(negedge clk);
      bus.sample_ack = 1'b0;
      checkOutput("stray_ack_valid", bus.sample_valid, 1'b0);
      checkOutput("stray_ack_start", bus.start_tx, 1'b0);

      // Single echo
      doReset();
      enable = 1'b1; delay_len = 10'd4; mix = 4'd8; feedback = 4'd0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus((i == 0) ? 8'hFF : 8'h80, 0, got);
         outs[i] = got;
      end
      checkOutput("echo_s0", outs[0], 8'hFF);
      checkOutput("echo_s3", outs[3], 8'h80);
      checkOutput("echo_s4", outs[4], 8'hBF);
      checkOutput("echo_s8", outs[8], 8'h80);

      // Feedback
      doReset();
      feedback = 4'd8;
      for (int i = 0; i < 13; i++) begin
         applyStimulus((i == 0) ? 8'hFF : 8'h80, 0, got);
         outs[i] = got;
      end
      checkOutput("fb_s4", outs[4], 8'hBF);
      checkOutput("fb_s8", outs[8], 8'h9F);
      checkOutput("fb_s12", outs[12], 8'h8F);

      // Saturation both rails
      doReset();
      delay_len = 10'd1; mix = 4'd15; feedback = 4'd15;
      for (int i = 0; i < 6; i++) applyStimulus(8'hFF, 0, got);
      checkOutput("sat_high", got, 8'hFF);
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(8'h00, 0, got);
      checkOutput("sat_low", got, 8'h00);

      // Edge arriving in the same cycle the ack returns to IDLE is dropped
      doReset();
      applyStimulus(8'h55, -1, got);
      @(negedge clk);
      bus.sample_ack = 1'b1;
      bus.data_rdy   = 1'b1;
      @(negedge clk);
      bus.sample_ack = 1'b0;
      checkOutput("ackedge_valid", bus.sample_valid, 1'b0);
      checkOutput("ackedge_start", bus.start_tx, 1'b0);
      checkOutput("ackedge_overrun", overrun, 1'b1);
      @(negedge clk);
      checkOutput("ackedge_start2", bus.start_tx, 1'b0);
      bus.data_rdy = 1'b0;

      // Wrap: longest delay across more than one full lap
      doReset();
      enable = 1'b1; delay_len = 10'(DEPTH - 1); mix = 4'd8; feedback = 4'd4;
      for (int i = 0; i < DEPTH + 5; i++) applyStimulus(8'($urandom_range(0, 255)), 0, got);

      // Overrun while the result waits for ack
      applyStimulus(8'h33, -1, outs[0]);
      bus.data_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("ovr_no_start", bus.start_tx, 1'b0);
      end
      checkOutput("ovr_flag", overrun, 1'b1);
      checkOutput("ovr_valid", bus.sample_valid, 1'b1);
      checkOutput("ovr_held_out", bus.sample_out, outs[0]);
      bus.sample_ack = 1'b1;
      @(negedge clk);
      bus.sample_ack = 1'b0;
      @(negedge clk);
      checkOutput("ovr_level_no_start", bus.start_tx, 1'b0);
      bus.data_rdy = 1'b0;
      @(negedge clk);
      checkOutput("ovr_sticky", overrun, 1'b1);
      doReset();
      checkOutput("ovr_cleared", overrun, 1'b0);

      // Reset in the middle of CALC
      enable = 1'b1; delay_len = 10'd2; mix = 4'd8; feedback = 4'd8;
      for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)), 0, got);
      @(negedge clk);
      bus.data_rdy = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (bus.start_tx !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("midrst_start", cyc, 0);
      bus.data_rdy = 1'b0;
      @(negedge clk);
      bus.data_adc = 8'hE0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midrst_start_tx", bus.start_tx, 1'b0);
      checkOutput("midrst_valid", bus.sample_valid, 1'b0);
      checkOutput("midrst_out", bus.sample_out, 8'h80);
      checkOutput("midrst_overrun", overrun, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      modelReset();
`ifdef PEDAL_ECHO_CLEAR_EN
      repeat (DEPTH + 4) @(negedge clk);
`endif
      for (int i = 0; i < 5; i++) applyStimulus(8'($urandom_range(0, 255)), 0, got);

      // Randomized settings and samples
      for (int i = 0; i < 60; i++) begin
         if (i % 8 == 0) begin
            enable    = 1'($urandom_range(0, 1));
            delay_len = 10'($urandom_range(0, 8));
            mix       = 4'($urandom_range(0, 15));
            feedback  = 4'($urandom_range(0, 15));
         end
         applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
